// File: rtl/flash_load_pkg.sv
// Shared definitions for the flash load sequencer: slot geometry, the
// sequencer state encoding and a lowest-set-bit helper for slot selection.
package flash_load_pkg;

  localparam int SLOT_W = 4;
  localparam int SLOT_N = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE,
    ST_SETTLE,
    ST_FINISH,
    ST_FAIL
  } state_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [SLOT_W-1:0] lowest_set(input logic [SLOT_N-1:0] m);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int i = SLOT_N - 1; i >= 0; i--) begin
      if (m[i]) idx = SLOT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/flash_load_timer.sv
// Loadable saturating down-counter. expired is high while the count is zero;
// the count stops at zero instead of wrapping.
module flash_load_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count_en,
  output logic         expired
);

  logic [W-1:0] count;

  // Load has priority over counting; counting halts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count_en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/flash_load_sequencer.sv
// Flash load sequencer: walks the selected image slots lowest-first, runs a
// four-phase handshake with the loader for each, then settles and releases
// the CPU. Optional macro FLASH_LOAD_RETRY_EN grants each slot one re-issue
// after its first timeout.
//
// Loader handshake (four-phase): ld_req rises with ld_slot already stable;
// the loader raises ld_complete when the slot is loaded; ld_req then drops;
// the loader lowers ld_complete; only then may a new ld_req rise. Each of
// the two waiting phases is bounded by TIMEOUT_CYCLES.
module flash_load_sequencer
  import flash_load_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int SETTLE_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SLOT_N-1:0] slot_mask,
  input  logic              ld_complete,
  output logic              ld_req,
  output logic [SLOT_W-1:0] ld_slot,
  output logic              cpu_hold,
  output logic              ram_owner,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [SLOT_W-1:0] err_slot,
  output state_t            state_dbg
);

  // The timer is shared with the settle count, so it is wide enough for both.
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int TMR_W = (TO_W > 8) ? TO_W : 8;
  localparam logic [TMR_W-1:0] TO_LOAD     = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

  state_t            state, state_next;
  logic [SLOT_N-1:0] pending;
  logic              tmr_load, tmr_count, tmr_expired;
  logic [TMR_W-1:0]  tmr_val;
  logic              clr_bit;
`ifdef FLASH_LOAD_RETRY_EN
  logic              retry_used;
  logic              take_retry;
`endif

  assign state_dbg = state;

  flash_load_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count_en (tmr_count),
    .expired  (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and timer control.
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = TO_LOAD;
    tmr_count  = 1'b0;
    clr_bit    = 1'b0;
`ifdef FLASH_LOAD_RETRY_EN
    take_retry = 1'b0;
`endif
    case (state)
      ST_IDLE: if (start) state_next = ST_SCAN;
      ST_SCAN: begin
        if (pending != '0) begin
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_SETTLE;
          tmr_load   = 1'b1;
          tmr_val    = SETTLE_LOAD;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
        tmr_load   = 1'b1;
      end
      ST_WAIT: begin
        // Completion wins over a timeout expiring in the same cycle.
        if (ld_complete) begin
          clr_bit    = 1'b1;
          tmr_load   = 1'b1;
          state_next = ST_RELEASE;
        end else if (tmr_expired) begin
`ifdef FLASH_LOAD_RETRY_EN
          if (!retry_used) begin
            take_retry = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_FAIL;
          end
`else
          state_next = ST_FAIL;
`endif
        end else begin
          tmr_count = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!ld_complete)     state_next = ST_SCAN;
        else if (tmr_expired) state_next = ST_FAIL;
        else                  tmr_count  = 1'b1;
      end
      ST_SETTLE: begin
        if (tmr_expired) state_next = ST_FINISH;
        else             tmr_count  = 1'b1;
      end
      ST_FINISH: state_next = ST_IDLE;
      ST_FAIL:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

`ifdef FLASH_LOAD_RETRY_EN
  // One retry per slot: armed by a first timeout, cleared by completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          retry_used <= 1'b0;
    else if (state == ST_IDLE && start)  retry_used <= 1'b0;
    else if (clr_bit)                    retry_used <= 1'b0;
    else if (take_retry)                 retry_used <= 1'b1;
  end
`endif

  // Registered outputs and the pending-slot register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_req    <= 1'b0;
      ld_slot   <= '0;
      cpu_hold  <= 1'b1;
      ram_owner <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_slot  <= '0;
      pending   <= '0;
    end else begin
      ld_req    <= (state_next == ST_WAIT);
      ram_owner <= (state_next == ST_ISSUE) || (state_next == ST_WAIT) ||
                   (state_next == ST_RELEASE);
      busy      <= (state_next != ST_IDLE);
      if (state == ST_IDLE && start) begin
        pending  <= slot_mask;
        done     <= 1'b0;
        error    <= 1'b0;
        err_slot <= '0;
        cpu_hold <= 1'b1;
      end
      if (state == ST_SCAN && pending != '0) ld_slot <= lowest_set(pending);
      if (clr_bit) pending[ld_slot] <= 1'b0;
      if (state == ST_SETTLE && state_next == ST_FINISH) cpu_hold <= 1'b0;
      if (state == ST_FINISH) done <= 1'b1;
      if (state == ST_FAIL) begin
        error    <= 1'b1;
        err_slot <= ld_slot;
      end
    end
  end

endmodule

// File: tb/tb_flash_load_sequencer.sv
// Bench for flash_load_sequencer: two instances (long and short timeout), a
// behavioural loader per instance driven by a per-request latency table, and
// a reference model that predicts slot order, total cycles and phase lengths.
module tb_flash_load_sequencer;
  import flash_load_pkg::*;

  localparam int T_A = 1024;
  localparam int S_A = 16;
  localparam int T_B = 64;
  localparam int S_B = 5;
`ifdef FLASH_LOAD_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start[2];
  logic [15:0] mask[2];
  logic        ldc[2];
  logic        ld_req[2];
  logic [3:0]  ld_slot[2];
  logic        cpu_hold[2];
  logic        ram_owner[2];
  logic        busy[2];
  logic        done[2];
  logic        error[2];
  logic [3:0]  err_slot[2];
  state_t      st[2];

  flash_load_sequencer #(.TIMEOUT_CYCLES(T_A), .SETTLE_CYCLES(S_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .slot_mask(mask[0]),
    .ld_complete(ldc[0]), .ld_req(ld_req[0]), .ld_slot(ld_slot[0]),
    .cpu_hold(cpu_hold[0]), .ram_owner(ram_owner[0]), .busy(busy[0]),
    .done(done[0]), .error(error[0]), .err_slot(err_slot[0]), .state_dbg(st[0])
  );

  flash_load_sequencer #(.TIMEOUT_CYCLES(T_B), .SETTLE_CYCLES(S_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .slot_mask(mask[1]),
    .ld_complete(ldc[1]), .ld_req(ld_req[1]), .ld_slot(ld_slot[1]),
    .cpu_hold(cpu_hold[1]), .ram_owner(ram_owner[1]), .busy(busy[1]),
    .done(done[1]), .error(error[1]), .err_slot(err_slot[1]), .state_dbg(st[1])
  );

  // scoreboard counters
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Loader behaviour per request: latency 0 = never answers, otherwise raise
  // ld_complete on the lat-th cycle of ld_req; hold it for extra cycles after
  // ld_req drops.
  int lat_tab[2][256];
  int hold_tab[2][256];
  int slot_log[2][256];
  int nreq[2] = '{0, 0};

  task automatic loader(input int u);
    ldc[u] = 1'b0;
    forever begin
      @(negedge clk);
      if (ld_req[u]) begin
        int idx;
        int lat;
        idx = nreq[u];
        lat = lat_tab[u][idx];
        slot_log[u][idx] = int'(ld_slot[u]);
        nreq[u] = idx + 1;
        for (int k = 1; k < lat && ld_req[u]; k++) @(negedge clk);
        if (ld_req[u] && lat != 0) begin
          ldc[u] = 1'b1;
          while (ld_req[u]) @(negedge clk);
          repeat (hold_tab[u][idx]) @(negedge clk);
          ldc[u] = 1'b0;
        end else begin
          while (ld_req[u]) @(negedge clk);
        end
      end
    end
  endtask

  initial fork
    loader(0);
    loader(1);
  join

  // phase-length monitors
  int hi_cnt[2]  = '{0, 0};
  int own_cnt[2] = '{0, 0};
  int rel_cnt[2] = '{0, 0};
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (ld_req[u])             hi_cnt[u]++;
      if (ram_owner[u])          own_cnt[u]++;
      if (st[u] == ST_RELEASE)   rel_cnt[u]++;
    end
  end

  task automatic set_req(input int u, input int k, input int l, input int h);
    lat_tab[u][nreq[u] + k]  = l;
    hold_tab[u][nreq[u] + k] = h;
  endtask

  // Reference model plus driver for one complete sequence.
  task automatic run_seq(input int u, input logic [15:0] m, input string tag);
    int tt, ss, r, cyc, hi, own, rel, fslot, edges, fall;
    int b_hi, b_own, b_rel, b_req, limit;
    bit fail;
    int exp_slots[$];
    tt = (u == 0) ? T_A : T_B;
    ss = (u == 0) ? S_A : S_B;
    r = nreq[u];
    cyc = 1;
    hi = 0; own = 0; rel = 0; fail = 1'b0; fslot = 0;
    for (int s = 0; s < 16; s++) begin
      if (m[s] && !fail) begin
        int tries;
        bit ok;
        tries = 0;
        ok = 1'b0;
        while (!ok && !fail) begin
          int l, h;
          l = lat_tab[u][r];
          h = hold_tab[u][r];
          r++;
          tries++;
          exp_slots.push_back(s);
          if (l >= 1 && l <= tt) begin
            cyc += 3 + l + h; hi += l; own += 2 + l + h; rel += 1 + h; ok = 1'b1;
          end else begin
            cyc += 1 + tt; hi += tt; own += 1 + tt;
            if (!(RETRY && tries == 1)) begin
              fail = 1'b1; fslot = s; cyc += 1;
            end
          end
        end
      end
    end
    if (!fail) cyc += ss + 1;

    b_hi = hi_cnt[u]; b_own = own_cnt[u]; b_rel = rel_cnt[u]; b_req = nreq[u];
    limit = cyc + 200;
    @(negedge clk);
    mask[u] = m;
    start[u] = 1'b1;
    edges = 0;
    fall = -1;
    while (1) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) start[u] = 1'b0;
      if (!cpu_hold[u] && fall < 0) fall = edges;
      if (done[u] || error[u] || edges > limit) break;
    end
    chk({tag, " cycles"},   edges, cyc + 1);
    chk({tag, " done"},     done[u], !fail);
    chk({tag, " error"},    error[u], fail);
    chk({tag, " err_slot"}, err_slot[u], fail ? fslot : 0);
    chk({tag, " cpu_hold"}, cpu_hold[u], fail);
    chk({tag, " busy"},     busy[u], 1'b0);
    chk({tag, " hold_fall"}, fall, fail ? -1 : cyc);
    chk({tag, " requests"}, nreq[u] - b_req, exp_slots.size());
    for (int i = 0; i < exp_slots.size(); i++)
      chk({tag, " slot"}, slot_log[u][b_req + i], exp_slots[i]);
    chk({tag, " req_cycles"},   hi_cnt[u] - b_hi, hi);
    chk({tag, " owner_cycles"}, own_cnt[u] - b_own, own);
    chk({tag, " release_cycles"}, rel_cnt[u] - b_rel, rel);
  endtask

  // directed and random stimulus
  initial begin
    int b;
    logic [15:0] m;
    start[0] = 1'b0; start[1] = 1'b0;
    mask[0] = '0;    mask[1] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ld_req",    ld_req[0], 1'b0);
    chk("reset ld_slot",   ld_slot[0], 4'd0);
    chk("reset ram_owner", ram_owner[0], 1'b0);
    chk("reset busy",      busy[0], 1'b0);
    chk("reset done",      done[0], 1'b0);
    chk("reset error",     error[0], 1'b0);
    chk("reset err_slot",  err_slot[0], 4'd0);
    chk("reset cpu_hold",  cpu_hold[0], 1'b1);
    chk("reset state",     st[0], ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    set_req(0, 0, 100, 0);
    set_req(0, 1, 100, 0);
    run_seq(0, 16'h0005, "two_slot");
    run_seq(0, 16'h0000, "empty");
    set_req(0, 0, 5, 10);
    set_req(0, 1, 3, 0);
    run_seq(0, 16'h0011, "hold_release");

    set_req(1, 0, 0, 0);
    set_req(1, 1, 7, 0);
    run_seq(1, 16'h0008, "slot3_timeout");
    set_req(1, 0, 0, 0);
    set_req(1, 1, 0, 0);
    run_seq(1, 16'h0008, "slot3_dead");
    set_req(1, 0, 64, 1);
    set_req(1, 1, 65, 0);
    set_req(1, 2, 3, 0);
    run_seq(1, 16'h8001, "edge_timeout");

    // reset during WAIT of slot 1, after a start pulse that must be ignored
    set_req(0, 0, 50, 0);
    @(negedge clk);
    mask[0] = 16'h0002;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 10 && st[0] != ST_WAIT; i++) @(negedge clk);
    chk("rst reach_wait", st[0], ST_WAIT);
    repeat (3) @(negedge clk);
    mask[0] = 16'hFFFF;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("busy_start state",   st[0], ST_WAIT);
    chk("busy_start ld_slot", ld_slot[0], 4'd1);
    chk("busy_start ld_req",  ld_req[0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst ld_req",    ld_req[0], 1'b0);
    chk("midrst busy",      busy[0], 1'b0);
    chk("midrst cpu_hold",  cpu_hold[0], 1'b1);
    chk("midrst ram_owner", ram_owner[0], 1'b0);
    chk("midrst state",     st[0], ST_IDLE);
    b = nreq[0];
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("postrst new_req", nreq[0] - b, 0);
    chk("postrst ld_req",  ld_req[0], 1'b0);
    chk("postrst busy",    busy[0], 1'b0);

    repeat (6) begin
      m = 16'($urandom_range(0, 65535));
      for (int k = 0; k < 16; k++) set_req(0, k, $urandom_range(1, 30), $urandom_range(0, 4));
      run_seq(0, m, "rand_a");
    end
    repeat (5) begin
      m = 16'($urandom) & 16'($urandom);
      for (int k = 0; k < 32; k++)
        set_req(1, k, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 66), $urandom_range(0, 3));
      run_seq(1, m, "rand_b");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_load_sequencer.md
FLASH_LOAD_SEQUENCER -- requirements
Module: flash_load_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1048576, max clk cycles allowed per slot load before timeout (range 2..2^24).
REQ-002 Parameter: SETTLE_CYCLES, default 16, clk cycles between last load completion and cpu_hold release (range 1..255).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a load sequence.
REQ-006 slot_mask  input  16  bit n=1 selects flash image slot n; sampled only on accepted start.
REQ-007 ld_req  output  1  four-phase request to the flash loader.
REQ-008 ld_slot  output  4  slot index presented to the loader; stable while ld_req=1.
REQ-009 ld_complete  input  1  loader completion; high while done, low after ld_req drops.
REQ-010 cpu_hold  output  1  holds target CPU in reset/halt while RAM is being filled.
REQ-011 ram_owner  output  1  RAM mux select: 1 = loader, 0 = CPU bus.
REQ-012 busy  output  1  sequence in progress.
REQ-013 done  output  1  sticky: sequence finished without error.
REQ-014 error  output  1  sticky: a slot timed out.
REQ-015 err_slot  output  4  slot index that caused error; 0 otherwise.

Function
REQ-016 FSM states: IDLE, SCAN, ISSUE, WAIT, RELEASE, SETTLE, FINISH, FAIL; one state per cycle unless stated.
REQ-017 IDLE: start=1 latches slot_mask into pending register, clears done/error/err_slot, enters SCAN next cycle; start ignored in every other state.
REQ-018 SCAN: selects lowest set pending bit as ld_slot and enters ISSUE; pending=0 enters SETTLE (empty mask yields done after SETTLE_CYCLES+1 cycles).
REQ-019 ISSUE: asserts ld_req, clears timeout counter, enters WAIT.
REQ-020 WAIT: ld_req held; ld_complete=1 clears that pending bit, drops ld_req, enters RELEASE; counter reaching TIMEOUT_CYCLES-1 without completion drops ld_req and enters FAIL.
REQ-021 RELEASE: waits for ld_complete=0, then SCAN; same timeout counter (restarted on entry) applies, expiry enters FAIL.
REQ-022 ld_complete=1 in the same cycle the counter expires counts as completion.
REQ-023 SETTLE: counts SETTLE_CYCLES cycles, then FINISH.
REQ-024 FINISH: sets done, returns to IDLE next cycle.
REQ-025 FAIL: sets error, records err_slot=ld_slot, returns to IDLE next cycle; cpu_hold remains 1 until next successful sequence.
REQ-026 busy=1 in all states except IDLE; ram_owner=1 in ISSUE, WAIT, RELEASE only.
REQ-027 cpu_hold=1 from accepted start through end of SETTLE; 0 in IDLE after done.
REQ-028 Timeout counter width = clog2(TIMEOUT_CYCLES); saturates, never wraps.
REQ-029 All outputs registered; ld_req rises one cycle after SCAN selects a slot.

Reset
REQ-030 rst_n=0 forces IDLE immediately: ld_req=0, ld_slot=0, ram_owner=0, busy=0, done=0, error=0, err_slot=0, pending=0, cpu_hold=1.
REQ-031 Reset mid-load abandons the sequence; the loader sees ld_req drop and no further request until a new start.

Configuration
REQ-032 Macro FLASH_LOAD_RETRY_EN defined: first timeout of a slot re-enters ISSUE once for that slot (retry flag cleared on slot completion); second timeout enters FAIL.
REQ-033 FLASH_LOAD_RETRY_EN undefined: first timeout enters FAIL; no retry logic synthesized.

Structure
REQ-034 Shared package flash_load_pkg holds the state enumeration, slot-index width (4) and slot count (16).
REQ-035 One sub-module, flash_load_timer: loadable saturating down-counter with expiry flag, reused by WAIT/RELEASE and SETTLE.

Verification
REQ-036 slot_mask=16'h0005, loader completes 100 cycles after ld_req -> ld_slot 0 then 2, done=1, error=0, cpu_hold falls SETTLE_CYCLES after second release.
REQ-037 slot_mask=16'h0000 -> no ld_req, done=1 after SETTLE_CYCLES+3 cycles.
REQ-038 TIMEOUT_CYCLES=64, slot 3 loader silent, retry off -> ld_req drops at cycle 64 of WAIT, error=1, err_slot=3, cpu_hold=1.
REQ-039 Same with FLASH_LOAD_RETRY_EN, loader answers on second request -> two ld_req pulses for slot 3, done=1, error=0.
REQ-040 rst_n low during WAIT of slot 1 -> ld_req=0, busy=0, cpu_hold=1 same cycle; start pulse during busy is ignored.
REQ-041 ld_complete held high after drop for 10 cycles -> FSM stays in RELEASE, next ld_req only after ld_complete=0.
